// File: rtl/jtroc_sndcmd.sv
// ---------------------------------------------------------------------------
// jtroc_sndcmd
//
// Main-to-sound command channel. The main CPU pushes command bytes into a
// small circular FIFO. The sound CPU reads them back one at a time. A rising
// edge on snd_on raises the sound-CPU interrupt (active low). The interrupt
// stays asserted until the sound CPU acknowledges it, or until HOLD_CNT
// snd_cen ticks have passed. Everything runs in the single clk domain.
//
// Handshake: main_we, latch_rd and irq_ack are single-cycle strobes. Each
// cycle a strobe is high counts as one event. There is no back-pressure.
// A write to a full FIFO is dropped and sets the sticky overflow flag.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  synchronous reset, active low
//   snd_cen    in   1  sound-CPU clock enable; drives only the IRQ timeout
//   main_we    in   1  push main_din into the FIFO
//   main_din   in   8  command byte
//   snd_on     in   1  trigger level; a rising edge requests an IRQ
//   mute_in    in   1  mute request
//   latch_rd   in   1  pop the FIFO head
//   irq_ack    in   1  acknowledge the IRQ
//   snd_latch  out  8  FIFO head, or the last popped byte when empty
//   snd_irqn   out  1  sound-CPU interrupt, active low
//   mute       out  1  mute_in after a 2-flop synchroniser
//   pending    out  5  FIFO occupancy, 0..DEPTH
//   overflow   out  1  sticky: a write was dropped because the FIFO was full
//   st_dout    out  8  debug: {overflow, ~snd_irqn, mute, pending}
// ---------------------------------------------------------------------------
module jtroc_sndcmd #(
    parameter int DEPTH    = 4,
    parameter int HOLD_CNT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       snd_cen,
    input  logic       main_we,
    input  logic [7:0] main_din,
    input  logic       snd_on,
    input  logic       mute_in,
    input  logic       latch_rd,
    input  logic       irq_ack,
    output logic [7:0] snd_latch,
    output logic       snd_irqn,
    output logic       mute,
    output logic [4:0] pending,
    output logic       overflow,
    output logic [7:0] st_dout
);

    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;      // one extra bit separates full from empty
    logic [AW:0] used;
    logic        empty, full;
    logic        push, pop;
    logic [AW:0] wr_ptr_next, rd_ptr_next, used_next;
    logic [7:0]  latch_next;

    assign used  = wr_ptr - rd_ptr;
    assign empty = (used == '0);
    assign full  = (used == (AW+1)'(DEPTH));
    assign push  = main_we && (!full || latch_rd);
    assign pop   = latch_rd && !empty;

    assign wr_ptr_next = push ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_next = pop  ? rd_ptr + 1'b1 : rd_ptr;
    assign used_next   = wr_ptr_next - rd_ptr_next;

    // The registered snd_latch follows the head as it will be after this cycle.
    // If the new head is the slot being written right now, take the byte
    // straight from main_din. If the FIFO drains, keep the last value.
    always_comb begin
        latch_next = snd_latch;
        if (used_next != '0) begin
            if (push && (rd_ptr_next[AW-1:0] == wr_ptr[AW-1:0]))
                latch_next = main_din;
            else
                latch_next = mem[rd_ptr_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            snd_latch <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            if (push)
                mem[wr_ptr[AW-1:0]] <= main_din;
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            snd_latch <= latch_next;
            if (main_we && full && !latch_rd)
                overflow <= 1'b1;
        end
    end

    assign pending = 5'(used);

    // ------------------------------------------------------------------
    // Mute synchroniser
    // ------------------------------------------------------------------
    logic mute_s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mute_s1 <= 1'b0;
            mute    <= 1'b0;
        end else begin
            mute_s1 <= mute_in;
            mute    <= mute_s1;
        end
    end

    // ------------------------------------------------------------------
    // IRQ state machine
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } irq_state_t;

    irq_state_t  state, state_next;
    logic        snd_on_d;
    logic        on_edge;
    logic [15:0] tick_cnt, tick_cnt_next;
    logic [15:0] tick_inc;
    logic        timeout;

    assign on_edge  = snd_on && !snd_on_d;
    // The counter saturates, so a large HOLD_CNT can never wrap it back to zero.
    assign tick_inc = (tick_cnt == 16'hFFFF) ? tick_cnt : tick_cnt + 16'd1;
    // The tick that brings the count up to HOLD_CNT releases the line.
    assign timeout  = (HOLD_CNT != 0) && snd_cen && (32'(tick_inc) >= 32'(HOLD_CNT));

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        case (state)
            IDLE: begin
                if (on_edge) begin
                    state_next    = ASSERT;
                    tick_cnt_next = 16'd0;
                end
            end
            ASSERT: begin
                // A fresh edge beats ack and timeout, and restarts the count.
                if (on_edge) begin
                    tick_cnt_next = 16'd0;
                end else if (irq_ack || timeout) begin
                    state_next    = IDLE;
                    tick_cnt_next = 16'd0;
                end else if (snd_cen) begin
                    tick_cnt_next = tick_inc;
                end
            end
            default: begin
                state_next    = IDLE;
                tick_cnt_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= 16'd0;
            snd_on_d <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            snd_on_d <= snd_on;
        end
    end

    assign snd_irqn = (state != ASSERT);

    // Debug view. Bit 6 shows the FSM state (1 = ASSERT).
    assign st_dout = {overflow, ~snd_irqn, mute, pending};

endmodule

// File: tb/tb_jtroc_sndcmd.sv
// ---------------------------------------------------------------------------
// tb_jtroc_sndcmd
//
// Directed bench for jtroc_sndcmd with DEPTH=4 and HOLD_CNT=4.
// Inputs change 1 time unit after each rising edge. Outputs are sampled
// 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_jtroc_sndcmd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       snd_cen;
    logic       main_we;
    logic [7:0] main_din;
    logic       snd_on;
    logic       mute_in;
    logic       latch_rd;
    logic       irq_ack;
    logic [7:0] snd_latch;
    logic       snd_irqn;
    logic       mute;
    logic [4:0] pending;
    logic       overflow;
    logic [7:0] st_dout;

    int checks   = 0;
    int failures = 0;

    jtroc_sndcmd #(.DEPTH(4), .HOLD_CNT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_cen   (snd_cen),
        .main_we   (main_we),
        .main_din  (main_din),
        .snd_on    (snd_on),
        .mute_in   (mute_in),
        .latch_rd  (latch_rd),
        .irq_ack   (irq_ack),
        .snd_latch (snd_latch),
        .snd_irqn  (snd_irqn),
        .mute      (mute),
        .pending   (pending),
        .overflow  (overflow),
        .st_dout   (st_dout)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Checking.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drivers.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        main_we  = 1'b1;
        main_din = d;
        tick();
        main_we  = 1'b0;
    endtask

    task automatic pop();
        latch_rd = 1'b1;
        tick();
        latch_rd = 1'b0;
    endtask

    // One snd_cen pulse every 6 clocks.
    task automatic cen_tick();
        tick(5);
        snd_cen = 1'b1;
        tick();
        snd_cen = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        snd_cen  = 1'b0;
        main_we  = 1'b0;
        main_din = 8'h00;
        snd_on   = 1'b0;
        mute_in  = 1'b0;
        latch_rd = 1'b0;
        irq_ack  = 1'b0;
        @(posedge clk);
        #1;
        tick(2);

        // Reset state.
        check("rst_latch",   snd_latch, 16'h00);
        check("rst_irqn",    snd_irqn,  16'h1);
        check("rst_mute",    mute,      16'h0);
        check("rst_pending", pending,   16'h0);
        check("rst_ovf",     overflow,  16'h0);
        check("rst_st",      st_dout,   16'h00);
        rst_n = 1'b1;
        tick();

        // Single push and pop.
        push(8'h5A);
        check("t1_pending", pending,   16'd1);
        check("t1_latch",   snd_latch, 16'h5A);
        pop();
        check("t1_pend0",   pending,   16'd0);
        check("t1_hold",    snd_latch, 16'h5A);

        // Overflow after five pushes into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) push(8'(i));
        check("t2_pending", pending,  16'd4);
        check("t2_ovf",     overflow, 16'h1);
        check("t2_st",      st_dout,  16'h84);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_rd%0d", i), snd_latch, 16'(i));
            pop();
        end
        check("t2_pend0", pending,   16'd0);
        check("t2_hold",  snd_latch, 16'h04);
        pop();  // pop while empty is ignored
        check("t2_epop_pend",  pending,   16'd0);
        check("t2_epop_latch", snd_latch, 16'h04);

        // Push and pop in the same cycle while full.
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("t3_full", pending, 16'd4);
        main_we  = 1'b1;
        main_din = 8'h77;
        latch_rd = 1'b1;
        tick();
        main_we  = 1'b0;
        latch_rd = 1'b0;
        check("t3_pend4", pending, 16'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_rd%0d", i), snd_latch, (i == 3) ? 16'h77 : 16'(i + 2));
            pop();
        end
        check("t3_pend0", pending, 16'd0);

        // Push and pop in the same cycle while empty: only the push happens.
        main_we  = 1'b1;
        main_din = 8'h33;
        latch_rd = 1'b1;
        tick();
        main_we  = 1'b0;
        latch_rd = 1'b0;
        check("t3e_pend",  pending,   16'd1);
        check("t3e_latch", snd_latch, 16'h33);
        pop();
        check("t3e_pend0", pending, 16'd0);

        // IRQ raised by a rising edge and cleared by ack.
        snd_on = 1'b1;
        tick();
        check("t4_irq_on",  snd_irqn, 16'h0);
        tick(3);
        check("t4_irq_hold", snd_irqn, 16'h0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t4_ack", snd_irqn, 16'h1);
        tick(3);
        check("t4_no_retrig", snd_irqn, 16'h1);
        snd_on = 1'b0;
        tick();

        // Mute synchroniser latency.
        mute_in = 1'b1;
        tick();
        check("mute_1clk", mute, 16'h0);
        tick();
        check("mute_2clk", mute, 16'h1);
        mute_in = 1'b0;
        tick(2);
        check("mute_off", mute, 16'h0);

        // Timeout after four snd_cen ticks.
        snd_on = 1'b1;
        tick();
        snd_on = 1'b0;
        check("t5_on", snd_irqn, 16'h0);
        for (int i = 1; i <= 3; i++) cen_tick();
        check("t5_tick3", snd_irqn, 16'h0);
        cen_tick();
        check("t5_tick4", snd_irqn, 16'h1);

        // A second edge after two ticks restarts the count.
        snd_on = 1'b1;
        tick();
        snd_on = 1'b0;
        cen_tick();
        cen_tick();
        snd_on = 1'b1;
        tick();
        snd_on = 1'b0;
        check("t5r_edge", snd_irqn, 16'h0);
        cen_tick();
        cen_tick();
        check("t5r_tick2", snd_irqn, 16'h0);
        cen_tick();
        check("t5r_tick3", snd_irqn, 16'h0);
        cen_tick();
        check("t5r_tick4", snd_irqn, 16'h1);

        // An edge and an ack in the same cycle: the edge wins.
        snd_on = 1'b1;
        tick();
        snd_on = 1'b0;
        tick();
        snd_on  = 1'b1;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("edge_ack", snd_irqn, 16'h0);
        snd_on = 1'b0;

        // Reset in ASSERT with three entries queued and overflow set.
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        push(8'hA5);
        pop();
        check("t6_pre_pend", pending,  16'd3);
        check("t6_pre_ovf",  overflow, 16'h1);
        check("t6_pre_irq",  snd_irqn, 16'h0);
        rst_n   = 1'b0;
        main_we = 1'b1;
        main_din = 8'hEE;
        snd_on  = 1'b1;
        tick();
        main_we = 1'b0;
        snd_on  = 1'b0;
        check("t6_irqn",  snd_irqn,  16'h1);
        check("t6_pend",  pending,   16'd0);
        check("t6_ovf",   overflow,  16'h0);
        check("t6_latch", snd_latch, 16'h00);
        rst_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
